// File: rtl/uart_rx_buffer_if.sv
// uart_rx_buffer_if: UART-chip side and CPU-side signals of the receive buffer.
// slave modport is the buffer's view; master is the view of whatever drives it.
interface uart_rx_buffer_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  // UART chip / ram1 bus side
  logic             data_ready;
  logic             rdn;
  logic             bus_req;
  logic             bus_grant;
  logic [7:0]       uart_data;
  // CPU memory-stage side
  logic             pop;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             clr_overflow;

  modport slave (
    input  data_ready, bus_grant, uart_data, pop, clr_overflow,
    output rdn, bus_req, rx_data, rx_valid, count, overflow
  );

  modport master (
    output data_ready, bus_grant, uart_data, pop, clr_overflow,
    input  rdn, bus_req, rx_data, rx_valid, count, overflow
  );
endinterface

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: reads bytes from the external UART chip over the shared ram1
// bus and queues them in a first-word-fall-through FIFO for the CPU.
// Optional feature macro: UART_RX_DROP_EN -- when defined, a byte arriving while
// the FIFO is full is still read (clearing the chip), discarded, and flagged in
// the sticky overflow bit. When undefined the block applies backpressure and
// leaves the byte in the chip; overflow then stays 0.
module uart_rx_buffer #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned RD_PULSE   = 2
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_buffer_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = (RD_PULSE > 1) ? $clog2(RD_PULSE) : 1;

  typedef enum logic [1:0] {IDLE, REQ, STROBE, RELEASE} state_e;

  logic                  sync1_q, dr_s_q;
  state_e                state_q, state_d;
  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic                  rdn_q, rdn_d;
  logic                  bus_req_q, bus_req_d;
  logic                  push_c;
  logic                  pop_fire_c;
  logic                  full_c;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [7:0]            rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  overflow_q, overflow_d;

  assign pop_fire_c = bus.pop & rx_valid_q;
  assign full_c     = (count_q == CNT_W'(DEPTH));

  // Two-flop synchronizer for the asynchronous data_ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      dr_s_q  <= 1'b0;
    end else begin
      sync1_q <= bus.data_ready;
      dr_s_q  <= sync1_q;
    end
  end

  // FSM and strobe-control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      rdn_q     <= 1'b1;
      bus_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      rdn_q     <= rdn_d;
      bus_req_q <= bus_req_d;
    end
  end

`ifdef UART_RX_DROP_EN
  logic drop_c;
`endif

  // Next-state logic: bus request, rdn strobe, and sampling of the byte
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    rdn_d     = 1'b1;
    bus_req_d = 1'b0;
    push_c    = 1'b0;
`ifdef UART_RX_DROP_EN
    drop_c    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef UART_RX_DROP_EN
        if (dr_s_q) begin
          state_d   = REQ;
          bus_req_d = 1'b1;
        end
`else
        if (dr_s_q && !full_c) begin
          state_d   = REQ;
          bus_req_d = 1'b1;
        end
`endif
      end
      REQ: begin
        bus_req_d = 1'b1;
        if (bus.bus_grant) begin
          state_d = STROBE;
          rdn_d   = 1'b0;
          pcnt_d  = PW'(RD_PULSE - 1);
        end
      end
      STROBE: begin
        // A grant dropped mid-strobe is ignored; the read always completes.
        if (pcnt_q == '0) begin
          state_d = RELEASE;
`ifdef UART_RX_DROP_EN
          if (full_c && !pop_fire_c) drop_c = 1'b1;
          else                       push_c = 1'b1;
`else
          // Entry to REQ required space and only pops happen meanwhile.
          push_c = 1'b1;
`endif
        end else begin
          pcnt_d    = pcnt_q - PW'(1);
          rdn_d     = 1'b0;
          bus_req_d = 1'b1;
        end
      end
      RELEASE: begin
        // Wait for the chip to drop data_ready so the same byte is not re-read
        if (!dr_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer/count update and registered head-of-queue output
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c)     wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop_fire_c) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    if (push_c && !pop_fire_c)      count_d = count_q + CNT_W'(1);
    else if (!push_c && pop_fire_c) count_d = count_q - CNT_W'(1);
    rx_valid_d = (count_d != '0);
    rx_data_d  = rx_data_q;
    if (count_d != '0) begin
      // New head is the byte being written when the queue was otherwise empty
      if (push_c && (rd_ptr_d == wr_ptr_q)) rx_data_d = bus.uart_data;
      else                                  rx_data_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO storage (no reset needed; reads are gated by count)
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= bus.uart_data;
  end

  // FIFO control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

`ifdef UART_RX_DROP_EN
  // Sticky lost-byte flag; a drop on the same edge as a clear wins
  assign overflow_d = drop_c | (overflow_q & ~bus.clr_overflow);
`else
  logic unused_clr;
  assign unused_clr = bus.clr_overflow;
  assign overflow_d = 1'b0;
`endif

  // Overflow register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow_q <= 1'b0;
    else      overflow_q <= overflow_d;
  end

  assign bus.rdn      = rdn_q;
  assign bus.bus_req  = bus_req_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule
